// File: rtl/result_display_ctrl_pkg.sv
// Shared types, segment encodings and helpers for the result display path.
// Segments are active-low with a on bit 0 and g on bit 6.
package result_display_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    localparam logic [6:0] DIGIT_SEG [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [1:0] {
        IDLE,
        ABS,
        SHIFT,
        LOAD
    } state_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (nibble <= 4'd9) seg = DIGIT_SEG[nibble];
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: signed/unsigned binary in over
// valid/ready, BCD magnitude, sign and overflow out with a done pulse.
module bin_to_bcd_seq
    import result_display_ctrl_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_BCD  = 12
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_signed,
    output logic               o_ready,
    output logic               o_done,
    output logic [NB_BCD-1:0]  o_bcd,
    output logic               o_neg,
    output logic               o_ovf
);

    localparam int CW = $clog2(NB_DATA + 2);

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               neg_q, neg_d;
    logic [NB_DATA:0]   mag_q, mag_d;
    logic [NB_BCD-1:0]  bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NB_BCD-1:0]  adj;
    logic [NB_DATA:0]   sext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sext    = {data_q[NB_DATA-1], data_q};
        adj     = bcd_q;
        for (int i = 0; i < NB_BCD / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    data_d  = i_data;
                    neg_d   = i_signed & i_data[NB_DATA-1];
                    state_d = ABS;
                end
            end
            ABS: begin
                // One extra bit so the most negative input yields its magnitude
                mag_d   = neg_q ? (~sext + 1'b1) : {1'b0, data_q};
                bcd_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = CW'(NB_DATA + 1);
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = {adj[NB_BCD-2:0], mag_q[NB_DATA]};
                mag_d = {mag_q[NB_DATA-1:0], 1'b0};
                ovf_d = ovf_q | adj[NB_BCD-1];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = LOAD;
            end
            LOAD: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_done  = (state_q == LOAD);
    assign o_bcd   = bcd_q;
    assign o_neg   = neg_q;
    assign o_ovf   = ovf_q;

endmodule

// File: rtl/result_display_ctrl.sv
// Result-to-display top: BCD converter, display latch, leading-zero
// blanking and time-multiplexed active-low 7-segment scan.
module result_display_ctrl
    import result_display_ctrl_pkg::*;
#(
    parameter int NB_DATA      = 8,
    parameter int NB_DIGITS    = 4,
    parameter int COUNTER_BITS = 17
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [NB_DATA-1:0]   i_data,
    input  logic                 i_signed,
    output logic                 o_ready,
    output logic                 o_ovf,
    output logic [6:0]           o_seg,
    output logic [NB_DIGITS-1:0] o_an
);

    localparam int NB_BCD = 4 * (NB_DIGITS - 1);
    localparam int IW     = $clog2(NB_DIGITS);

    logic                    conv_done;
    logic [NB_BCD-1:0]       conv_bcd;
    logic                    conv_neg;
    logic                    conv_ovf;

    logic [NB_BCD-1:0]       disp_bcd_q;
    logic                    disp_neg_q;
    logic                    ovf_q;
    logic [COUNTER_BITS-1:0] presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NB_DIGITS-1:0]    an_q, an_d;
    logic [NB_DIGITS-2:0]    lead_nz;
    logic                    nz;
    logic [6:0]              dig_seg [NB_DIGITS];

    bin_to_bcd_seq #(
        .NB_DATA (NB_DATA),
        .NB_BCD  (NB_BCD)
    ) u_conv (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .i_signed (i_signed),
        .o_ready  (o_ready),
        .o_done   (conv_done),
        .o_bcd    (conv_bcd),
        .o_neg    (conv_neg),
        .o_ovf    (conv_ovf)
    );

    always_comb begin
        lead_nz = '0;
        nz      = 1'b0;
        dig_seg = '{default: SEG_BLANK};
        // lead_nz[d]: digit d or some higher magnitude digit is non-zero
        for (int d = NB_DIGITS - 2; d >= 0; d--) begin
            nz         = nz | (disp_bcd_q[4*d +: 4] != 4'd0);
            lead_nz[d] = nz;
        end
        for (int d = 0; d < NB_DIGITS - 1; d++) begin
            if (ovf_q)
                dig_seg[d] = SEG_MINUS;
            else if (d == 0 || lead_nz[d])
                dig_seg[d] = bcd_to_seg(disp_bcd_q[4*d +: 4]);
        end
        dig_seg[NB_DIGITS-1] = (ovf_q | disp_neg_q) ? SEG_MINUS : SEG_BLANK;

        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (&presc_q) begin
            idx_d = (idx_q == IW'(NB_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        seg_d = dig_seg[idx_q];
        an_d  = ~(NB_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp_bcd_q <= '0;
            disp_neg_q <= 1'b0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= DIGIT_SEG[0];
            an_q       <= {{(NB_DIGITS-1){1'b1}}, 1'b0};
        end else begin
            if (conv_done) begin
                disp_bcd_q <= conv_bcd;
                disp_neg_q <= conv_neg;
                ovf_q      <= conv_ovf;
            end
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign o_ovf = ovf_q;
    assign o_seg = seg_q;
    assign o_an  = an_q;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Directed bench for result_display_ctrl: 4-digit and 3-digit instances
// with a 4-bit scan prescaler, checked with immediate assertions.
module tb_result_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v4 = 1'b0, s4 = 1'b0;
    logic [7:0] d4 = '0;
    logic       rdy4, ovf4;
    logic [6:0] seg4;
    logic [3:0] an4;

    logic       v3 = 1'b0, s3 = 1'b0;
    logic [7:0] d3 = '0;
    logic       rdy3, ovf3;
    logic [6:0] seg3;
    logic [2:0] an3;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] MI = 7'h3F;

    always #5 clk = ~clk;

    result_display_ctrl #(.NB_DATA(8), .NB_DIGITS(4), .COUNTER_BITS(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .i_data(d4),
        .i_signed(s4), .o_ready(rdy4), .o_ovf(ovf4), .o_seg(seg4), .o_an(an4)
    );

    result_display_ctrl #(.NB_DATA(8), .NB_DIGITS(3), .COUNTER_BITS(4)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .i_data(d3),
        .i_signed(s3), .o_ready(rdy3), .o_ovf(ovf3), .o_seg(seg3), .o_an(an3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] an_of(input int w);
        return (w == 3) ? {13'd0, an3} : {12'd0, an4};
    endfunction

    // Wait for digit d to be scanned, then compare its segments.
    task automatic check_dig(input int w, input int d, input logic [6:0] exp, input string tag);
        logic [15:0] tgt;
        tgt = (w == 3) ? {13'd0, ~(3'd1 << d)} : {12'd0, ~(4'd1 << d)};
        for (int i = 0; i < 80; i++) begin
            if (an_of(w) == tgt) break;
            @(negedge clk);
        end
        chk({tag, "_an"}, an_of(w), tgt);
        chk(tag, (w == 3) ? {9'd0, seg3} : {9'd0, seg4}, {9'd0, exp});
    endtask

    // Present one transaction; returns at the negedge after the accept edge.
    task automatic send(input int w, input logic [7:0] d, input logic s);
        @(negedge clk);
        if (w == 3) begin v3 = 1'b1; d3 = d; s3 = s; end
        else begin v4 = 1'b1; d4 = d; s4 = s; end
        @(negedge clk);
        v3 = 1'b0;
        v4 = 1'b0;
    endtask

    // From the negedge after the accept edge: LOAD is cycle 11, ready in 12.
    task automatic wait_done(input int w, input int already, input string tag);
        repeat (10 - already) @(negedge clk);
        chk({tag, "_busy"}, (w == 3) ? {15'd0, rdy3} : {15'd0, rdy4}, 16'd0);
        @(negedge clk);
        chk({tag, "_ready"}, (w == 3) ? {15'd0, rdy3} : {15'd0, rdy4}, 16'd1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_ready", {15'd0, rdy4}, 16'd1);
        chk("rst_ovf", {15'd0, ovf4}, 16'd0);
        chk("rst_an", {12'd0, an4}, 16'hE);
        chk("rst_seg", {9'd0, seg4}, 16'h40);
        rst_n = 1'b1;

        check_dig(4, 0, 7'h40, "scan_d0");
        check_dig(4, 1, BL, "scan_d1");
        n = 0;
        while (an4 == 4'b1101 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scan_period", 16'(n), 16'd16);
        chk("scan_next_an", {12'd0, an4}, 16'hB);
        check_dig(4, 2, BL, "scan_d2");
        check_dig(4, 3, BL, "scan_d3");
        check_dig(4, 0, 7'h40, "scan_wrap");

        send(4, 8'hFB, 1'b1);
        wait_done(4, 0, "m5");
        chk("m5_ovf", {15'd0, ovf4}, 16'd0);
        check_dig(4, 3, MI, "m5_d3");
        check_dig(4, 2, BL, "m5_d2");
        check_dig(4, 1, BL, "m5_d1");
        check_dig(4, 0, 7'h12, "m5_d0");

        send(4, 8'hFB, 1'b0);
        wait_done(4, 0, "u251");
        check_dig(4, 3, BL, "u251_d3");
        check_dig(4, 2, 7'h24, "u251_d2");
        check_dig(4, 1, 7'h12, "u251_d1");
        check_dig(4, 0, 7'h79, "u251_d0");

        send(4, 8'h80, 1'b1);
        wait_done(4, 0, "m128");
        check_dig(4, 3, MI, "m128_d3");
        check_dig(4, 2, 7'h79, "m128_d2");
        check_dig(4, 1, 7'h24, "m128_d1");
        check_dig(4, 0, 7'h00, "m128_d0");

        send(3, 8'hC8, 1'b0);
        wait_done(3, 0, "ovf200");
        chk("ovf200_ovf", {15'd0, ovf3}, 16'd1);
        check_dig(3, 2, MI, "ovf200_d2");
        check_dig(3, 1, MI, "ovf200_d1");
        check_dig(3, 0, MI, "ovf200_d0");

        send(3, 8'h2A, 1'b0);
        wait_done(3, 0, "u42");
        chk("u42_ovf", {15'd0, ovf3}, 16'd0);
        check_dig(3, 2, BL, "u42_d2");
        check_dig(3, 1, 7'h19, "u42_d1");
        check_dig(3, 0, 7'h24, "u42_d0");

        send(4, 8'h07, 1'b0);
        repeat (2) @(negedge clk);
        v4 = 1'b1; d4 = 8'h63; s4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        wait_done(4, 3, "dbl");
        check_dig(4, 0, 7'h78, "dbl_d0");
        check_dig(4, 1, BL, "dbl_d1");
        repeat (2) @(negedge clk);
        chk("dbl_idle", {15'd0, rdy4}, 16'd1);

        send(4, 8'h80, 1'b1);
        repeat (4) @(negedge clk);
        chk("mid_busy", {15'd0, rdy4}, 16'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_ready", {15'd0, rdy4}, 16'd1);
        chk("mid_an", {12'd0, an4}, 16'hE);
        chk("mid_seg", {9'd0, seg4}, 16'h40);
        chk("mid_ovf", {15'd0, ovf4}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_dig(4, 1, BL, "mid_d1");
        check_dig(4, 0, 7'h40, "mid_d0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
